// File: rtl/hevc_interp_pkg.sv
// Shared types and constants for the HEVC 8-tap interpolation actors
// (real-size derivation, row sequencer and their neighbours).
package hevc_interp_pkg;

  localparam int SIZE_WIDTH_DEF = 7;
  // Extra rows an 8-tap filter needs beyond the block size; used by the derive stage.
  localparam int DIFF = 7;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_RUN  = 1'b1
  } seq_state_e;

  // Row token layout for the default two-flux configuration.
  typedef struct packed {
    logic [0:0]                tag;
    logic                      last;
    logic [SIZE_WIDTH_DEF-1:0] idx;
  } row_tok_t;

endpackage

// File: rtl/real_size_row_sequencer_8tap_if.sv
// FIFO-side bundles of the row sequencer: the multi-flux real-size read port
// and the single row-token write port.

// read/empty: a pop (read[i]=1) is only legal while empty[i]=0; dout is the
// head token and is consumed on the clock edge where read is high.
// write/full: a push (write=1) happens on the edge where write is high and
// full is low; the producer never raises write while full is high.
interface rs_fifo_rd_if #(
  parameter int FLUX       = 2,
  parameter int SIZE_WIDTH = 7
);
  localparam int TAG_WIDTH = $clog2(FLUX);
  localparam int IN_WIDTH  = SIZE_WIDTH + TAG_WIDTH;

  logic [FLUX-1:0]     empty;
  logic [IN_WIDTH-1:0] dout;
  logic [FLUX-1:0]     read;

  modport master (input empty, input dout, output read);
  modport slave  (output empty, output dout, input read);
endinterface

interface row_fifo_wr_if #(
  parameter int FLUX       = 2,
  parameter int SIZE_WIDTH = 7
);
  localparam int TAG_WIDTH = $clog2(FLUX);
  localparam int OUT_WIDTH = TAG_WIDTH + 1 + SIZE_WIDTH;

  logic                 full;
  logic                 write;
  logic [OUT_WIDTH-1:0] din;

  modport master (input full, output write, output din);
  modport slave  (output full, input write, input din);
endinterface

// File: rtl/real_size_row_sequencer_8tap_flux_priority_select.sv
// Fixed-priority flux picker: lowest-numbered non-empty flux wins.
// Shared by the derive stage and other multi-flux actors.
module flux_priority_select #(
  parameter int FLUX      = 2,
  parameter int TAG_WIDTH = $clog2(FLUX)
) (
  input  logic [FLUX-1:0]      empty,
  output logic [TAG_WIDTH-1:0] sel,
  output logic                 any_valid
);

  always_comb begin
    sel       = '0;
    any_valid = ~&empty;
    // Walk from the top down so the lowest non-empty index is written last.
    for (int i = FLUX - 1; i >= 0; i--) begin
      if (!empty[i]) begin
        sel = TAG_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/real_size_row_sequencer_8tap.sv
// Expands one real-size token per block into row-index tokens 0..size-1,
// locked to a single flux for the whole block.
module real_size_row_sequencer_8tap
  import hevc_interp_pkg::*;
#(
  parameter int FLUX       = 2,
  parameter int SIZE_WIDTH = SIZE_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  rs_fifo_rd_if.master        read_port_real_size,
  row_fifo_wr_if.master       write_port_row,
  output seq_state_e          dbg_state_o
);

  localparam int TAG_WIDTH = $clog2(FLUX);
  localparam int IN_WIDTH  = SIZE_WIDTH + TAG_WIDTH;
  localparam int OUT_WIDTH = TAG_WIDTH + 1 + SIZE_WIDTH;

  seq_state_e            state_q, state_d;
  logic [TAG_WIDTH-1:0]  cur_tag_q, cur_tag_d;
  logic [SIZE_WIDTH-1:0] cur_size_q, cur_size_d;
  logic [SIZE_WIDTH-1:0] row_cnt_q, row_cnt_d;

  logic [TAG_WIDTH-1:0]  sel;
  logic                  any_valid;
  logic [SIZE_WIDTH-1:0] size_in;
  logic                  last_row;
  logic [FLUX-1:0]       read_v;
  logic                  write_v;
  logic [OUT_WIDTH-1:0]  din_v;
  logic                  unused_dout_tag;

  flux_priority_select #(
    .FLUX      (FLUX),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_sel (
    .empty     (read_port_real_size.empty),
    .sel       (sel),
    .any_valid (any_valid)
  );

  assign size_in         = read_port_real_size.dout[SIZE_WIDTH-1:0];
  // The tag carried in the token is redundant with the flux we popped from.
  assign unused_dout_tag = ^read_port_real_size.dout[IN_WIDTH-1:SIZE_WIDTH];
  assign last_row        = (row_cnt_q == (cur_size_q - SIZE_WIDTH'(1)));

  always_comb begin
    state_d    = state_q;
    cur_tag_d  = cur_tag_q;
    cur_size_d = cur_size_q;
    row_cnt_d  = row_cnt_q;
    read_v     = '0;
    write_v    = 1'b0;
    din_v      = '0;
    case (state_q)
      SEQ_IDLE: begin
        // Popping ignores downstream space; a zero-size token is simply dropped.
        if (any_valid) begin
          read_v[sel] = 1'b1;
          cur_tag_d   = sel;
          cur_size_d  = size_in;
          row_cnt_d   = '0;
          if (size_in != '0) begin
            state_d = SEQ_RUN;
          end
        end
      end
      SEQ_RUN: begin
        if (!write_port_row.full) begin
          write_v = 1'b1;
          din_v   = {cur_tag_q, last_row, row_cnt_q};
          if (last_row) begin
            state_d   = SEQ_IDLE;
            row_cnt_d = '0;
          end else begin
            row_cnt_d = row_cnt_q + SIZE_WIDTH'(1);
          end
        end
      end
      default: begin
        state_d = SEQ_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SEQ_IDLE;
      cur_tag_q  <= '0;
      cur_size_q <= '0;
      row_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cur_tag_q  <= cur_tag_d;
      cur_size_q <= cur_size_d;
      row_cnt_q  <= row_cnt_d;
    end
  end

  // Strobes are combinational, so gate them with reset to drop them immediately.
  assign read_port_real_size.read = rst_n ? read_v  : '0;
  assign write_port_row.write     = rst_n ? write_v : 1'b0;
  assign write_port_row.din       = rst_n ? din_v   : '0;
  assign dbg_state_o              = state_q;

endmodule
